// File: rtl/rr_arbiter_pkg.sv
// Shared types and default constants for the round-robin arbiter.
// Optional grant timeout is enabled with macro RR_ARB_TIMEOUT_EN.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_e;

  localparam int RR_ARB_N_REQ    = 2;
  localparam int RR_ARB_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate/priority search: first set request bit above last,
// wrapping modulo N_REQ.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N_REQ = RR_ARB_N_REQ
) (
  input  logic [N_REQ-1:0]         request,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         win_oh,
  output logic [$clog2(N_REQ)-1:0] win_id,
  output logic                     any
);

  localparam int IDW = $clog2(N_REQ);

  int idx;

  always_comb begin
    win_id = '0;
    any    = 1'b0;
    idx    = 0;
    // k = N_REQ lands back on last itself, so it has lowest priority
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && request[idx]) begin
        any    = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    win_oh = '0;
    if (any) win_oh[win_id] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a dead cycle between owners.
// Macro RR_ARB_TIMEOUT_EN adds a hold counter that revokes grants after MAX_HOLD cycles.
//
// state   | meaning
// IDLE    | no owner; arbitrate among pending requests at next edge
// GRANTED | grant held until owner drops request (or hold limit with contention)
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N_REQ    = RR_ARB_N_REQ,
  parameter int MAX_HOLD = RR_ARB_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         request,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter: N_REQ must be 2..16 and MAX_HOLD at least 1");
  end

  arb_state_e       state;
  logic [IDW-1:0]   last;
  logic [N_REQ-1:0] win_oh;
  logic [IDW-1:0]   win_id;
  logic             any;
  logic             owner_req;
  logic             revoke;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .request (request),
    .last    (last),
    .win_oh  (win_oh),
    .win_id  (win_id),
    .any     (any)
  );

  assign owner_req = request[grant_id];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_cnt;
  logic          others;

  assign others = |(request & ~grant);
  // revoke on the edge where the count would reach MAX_HOLD, or later once saturated
  assign revoke = others && (hold_cnt >= HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == IDLE) begin
      hold_cnt <= '0;
    end else if (hold_cnt < HW'(MAX_HOLD)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign revoke = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last     <= IDW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            grant    <= win_oh;
            grant_id <= win_id;
            state    <= GRANTED;
          end
        end
        GRANTED: begin
          if (!owner_req || revoke) begin
            grant <= '0;
            last  <= grant_id;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter; expectations are queued with
// each stimulus step and popped after the sampling edge.
module tb_rr_arbiter;

  localparam int N = 2;

  typedef struct packed {
    logic [N-1:0] g;
    logic         id;
    logic         idchk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] request = '0;
  logic [N-1:0] grant;
  logic         grant_id;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  rr_arbiter #(.N_REQ(N), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .request  (request),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", tag, $time, act, req);
    end
  endtask

  // drive request, then check outputs one edge later
  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] eg,
                     input logic eid, input logic idchk);
    exp_t e;
    request = req;
    exp_q.push_back('{g: eg, id: eid, idchk: idchk});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("grant", grant, e.g);
      if (e.idchk) check("grant_id", {1'b0, grant_id}, {1'b0, e.id});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2'b00, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // single requester grant and release
    cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // contention right after reset, handoff with dead cycle, stale id
    do_reset();
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 2'b10, 1'b1, 1'b1);
    cyc(2'b10, 2'b10, 1'b1, 1'b1);
    cyc(2'b00, 2'b00, 1'b1, 1'b1);

    // fairness: wrap to 0, then 0 re-raises but 1 goes next
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b10, 1'b1, 1'b1);
    cyc(2'b11, 2'b10, 1'b1, 1'b1);

    // reset during grant drops it and restores priority to 0
    rst = 1'b1;
    cyc(2'b11, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // idle stays idle
    for (int i = 0; i < 10; i++) cyc(2'b00, 2'b00, 1'b0, 1'b0);

    // non-owner toggles are ignored and never queued
    cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 2'b00, 1'b0, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // MAX_HOLD=4 under contention: 01 x4, 00, 10 x4, 00, 01
    do_reset();
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'b10, 1'b1, 1'b1);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b01, 1'b0, 1'b1);
    // lone requester holds past MAX_HOLD; later contention revokes at once
    do_reset();
    for (int i = 0; i < 12; i++) cyc(2'b01, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 2'b00, 1'b0, 1'b0);
    cyc(2'b11, 2'b10, 1'b1, 1'b1);
`else
    // without timeout the owner keeps the grant under contention
    do_reset();
    for (int i = 0; i < 12; i++) cyc(2'b11, 2'b01, 1'b0, 1'b1);
    cyc(2'b10, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 2'b10, 1'b1, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
